// File: rtl/hevc_interp_pkg.sv
// Shared constants for the HEVC luma 8-tap interpolation stream: coefficient
// table, phase/mode encodings and output arithmetic constants.
package hevc_interp_pkg;

    localparam logic [1:0] FRAC_INT  = 2'd0;
    localparam logic [1:0] FRAC_Q1   = 2'd1;
    localparam logic [1:0] FRAC_HALF = 2'd2;
    localparam logic [1:0] FRAC_Q3   = 2'd3;

    localparam logic MODE_FINAL = 1'b0;
    localparam logic MODE_INTER = 1'b1;

    localparam int INTER_W     = 16;
    localparam int ROUND_SHIFT = 6;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_BLOCK = 1'b1
    } blk_state_t;

    typedef logic signed [6:0] coef_t;

    // Row FRAC_INT is all zero: the integer phase bypasses the MAC entirely.
    localparam coef_t COEF_TAB [4][8] = '{
        '{ 7'sd0,  7'sd0,   7'sd0,  7'sd0,  7'sd0,   7'sd0,  7'sd0,  7'sd0},
        '{-7'sd1,  7'sd4, -7'sd10, 7'sd58, 7'sd17,  -7'sd5,  7'sd1,  7'sd0},
        '{-7'sd1,  7'sd4, -7'sd11, 7'sd40, 7'sd40, -7'sd11,  7'sd4, -7'sd1},
        '{ 7'sd0,  7'sd1,  -7'sd5, 7'sd17, 7'sd58, -7'sd10,  7'sd4, -7'sd1}
    };

endpackage

// File: rtl/hevc_fir8_lane.sv
// One output lane: per-tap products in S1, sum/round/clip in S2.
// Optional clip flag output when HEVC_FIR_CLIP_STATS_EN is defined.
module hevc_fir8_lane
    import hevc_interp_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en1,
    input  logic                   i_en2,
    input  logic [8*BIT_DEPTH-1:0] i_pix,
    input  logic [1:0]             i_frac,
    input  logic [1:0]             i_s1_frac,
    input  logic                   i_s1_mode,
`ifdef HEVC_FIR_CLIP_STATS_EN
    output logic                   o_clip,
`endif
    output logic [INTER_W-1:0]     o_data
);

    localparam int ACC_W = BIT_DEPTH + 8;
    localparam logic signed [ACC_W-1:0] PIX_MAX = $signed({8'd0, {BIT_DEPTH{1'b1}}});
    localparam logic signed [ACC_W-1:0] RND_OFS = ACC_W'(1 << (ROUND_SHIFT - 1));

    logic signed [ACC_W-1:0] w_prod [8];
    logic signed [ACC_W-1:0] r_prod [8];
    logic [BIT_DEPTH-1:0]    r_pix3;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_rnd;
    logic signed [ACC_W-1:0] w_sat;
    logic [INTER_W-1:0]      w_data;
    logic [INTER_W-1:0]      r_data;

    // S1 tap products: pixels are unsigned, so zero-extend before the signed multiply
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_prod[k] = $signed(ACC_W'({1'b0, i_pix[k*BIT_DEPTH +: BIT_DEPTH]}))
                        * ACC_W'(COEF_TAB[i_frac][k]);
        end
    end

    // S1 register: products plus the centre pixel for the integer phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                r_prod[k] <= '0;
            end
            r_pix3 <= '0;
        end else if (i_en1) begin
            r_prod <= w_prod;
            r_pix3 <= i_pix[3*BIT_DEPTH +: BIT_DEPTH];
        end
    end

    // S2 adder tree, rounding, clipping and output format select
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 8; k++) begin
            w_sum = w_sum + r_prod[k];
        end
        w_rnd = (w_sum + RND_OFS) >>> ROUND_SHIFT;
        if (w_rnd[ACC_W-1]) begin
            w_sat = '0;
        end else if (w_rnd > PIX_MAX) begin
            w_sat = PIX_MAX;
        end else begin
            w_sat = w_rnd;
        end
        case ({i_s1_frac == FRAC_INT, i_s1_mode})
            2'b10:   w_data = INTER_W'(r_pix3);
            2'b11:   w_data = INTER_W'({r_pix3, {(14-BIT_DEPTH){1'b0}}});
            2'b01:   w_data = INTER_W'(w_sum >>> (BIT_DEPTH - 8));
            default: w_data = INTER_W'(w_sat);
        endcase
    end

    // S2 output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (i_en2) begin
            r_data <= w_data;
        end
    end

    assign o_data = r_data;

`ifdef HEVC_FIR_CLIP_STATS_EN
    logic r_clip;

    // Clip flag travels with the S2 sample; only final-mode filtered samples count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clip <= 1'b0;
        end else if (i_en2) begin
            r_clip <= (w_rnd[ACC_W-1] || (w_rnd > PIX_MAX))
                      && (i_s1_frac != FRAC_INT) && (i_s1_mode == MODE_FINAL);
        end
    end

    assign o_clip = r_clip;
`endif

endmodule

// File: rtl/hevc_luma_fir_stream.sv
// Streaming HEVC luma 8-tap interpolator: LANES samples per beat, 2-stage pipe,
// per-block phase/mode. HEVC_FIR_CLIP_STATS_EN adds the clip_cnt statistic port.
module hevc_luma_fir_stream
    import hevc_interp_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int BIT_DEPTH = 8,
    parameter int BLOCK_H   = 8,
    parameter int ROW_W     = $clog2(BLOCK_H)
) (
    input  logic                           clk,
    input  logic                           rst,
`ifdef HEVC_FIR_CLIP_STATS_EN
    output logic [15:0]                    clip_cnt,
`endif
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(LANES+7)*BIT_DEPTH-1:0] in_pixels,
    input  logic [1:0]                     in_frac,
    input  logic                           in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*INTER_W-1:0]       out_data,
    output logic [ROW_W-1:0]               out_row,
    output logic                           out_last
);

    blk_state_t       r_state, w_state_nxt;
    logic [ROW_W-1:0] r_row, w_row_nxt, w_beat_row;
    logic [1:0]       r_cfg_frac, w_frac_nxt, w_beat_frac;
    logic             r_cfg_mode, w_mode_nxt, w_beat_mode;
    logic             w_beat_last;
    logic             r_alive;
    logic             r_s1_valid, r_s1_mode, r_s1_last;
    logic [1:0]       r_s1_frac;
    logic [ROW_W-1:0] r_s1_row;
    logic             r_s2_valid, r_s2_last;
    logic [ROW_W-1:0] r_s2_row;
    logic             w_s1_adv, w_s2_adv, w_acc;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    // r_alive keeps in_ready low until the first clock after reset release
    assign in_ready = r_alive && w_s1_adv;
    assign w_acc    = in_valid && in_ready;

    // Block FSM: config is sampled only on the first beat of a block
    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_frac_nxt  = r_cfg_frac;
        w_mode_nxt  = r_cfg_mode;
        w_beat_frac = r_cfg_frac;
        w_beat_mode = r_cfg_mode;
        w_beat_row  = r_row;
        case (r_state)
            ST_IDLE: begin
                w_beat_frac = in_frac;
                w_beat_mode = in_mode;
                w_beat_row  = '0;
            end
            default: begin
                w_beat_row = r_row;
            end
        endcase
        w_beat_last = (w_beat_row == ROW_W'(BLOCK_H - 1));
        if (w_acc) begin
            w_frac_nxt = w_beat_frac;
            w_mode_nxt = w_beat_mode;
            if (w_beat_last) begin
                w_state_nxt = ST_IDLE;
                w_row_nxt   = '0;
            end else begin
                w_state_nxt = ST_IN_BLOCK;
                w_row_nxt   = w_beat_row + ROW_W'(1);
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // FSM state, row counter and held block config
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_cfg_frac <= FRAC_INT;
            r_cfg_mode <= MODE_FINAL;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_cfg_frac <= w_frac_nxt;
            r_cfg_mode <= w_mode_nxt;
        end
    end

    // Pipeline valid bits and sideband travelling with each beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive    <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_frac  <= FRAC_INT;
            r_s1_mode  <= MODE_FINAL;
            r_s1_row   <= '0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_row   <= '0;
            r_s2_last  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_s1_adv) begin
                r_s1_valid <= w_acc;
                r_s1_frac  <= w_beat_frac;
                r_s1_mode  <= w_beat_mode;
                r_s1_row   <= w_beat_row;
                r_s1_last  <= w_beat_last;
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                r_s2_row   <= r_s1_row;
                r_s2_last  <= r_s1_last;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_row   = r_s2_row;
    assign out_last  = r_s2_last;

`ifdef HEVC_FIR_CLIP_STATS_EN
    logic [LANES-1:0] w_clip;
    logic [16:0]      w_clip_sum;
    logic [15:0]      r_clip_cnt;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hevc_fir8_lane #(
            .BIT_DEPTH (BIT_DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_en1     (w_s1_adv),
            .i_en2     (w_s2_adv),
            .i_pix     (in_pixels[g*BIT_DEPTH +: 8*BIT_DEPTH]),
            .i_frac    (w_beat_frac),
            .i_s1_frac (r_s1_frac),
            .i_s1_mode (r_s1_mode),
`ifdef HEVC_FIR_CLIP_STATS_EN
            .o_clip    (w_clip[g]),
`endif
            .o_data    (out_data[g*INTER_W +: INTER_W])
        );
    end

`ifdef HEVC_FIR_CLIP_STATS_EN
    // Population count of clipped lanes added to the running total
    always_comb begin
        w_clip_sum = {1'b0, r_clip_cnt};
        for (int i = 0; i < LANES; i++) begin
            w_clip_sum = w_clip_sum + 17'(w_clip[i]);
        end
    end

    // Saturating clip counter, advanced on each output handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clip_cnt <= 16'h0000;
        end else if (r_s2_valid && out_ready) begin
            r_clip_cnt <= w_clip_sum[16] ? 16'hFFFF : w_clip_sum[15:0];
        end
    end

    assign clip_cnt = r_clip_cnt;
`endif

endmodule

// File: doc/hevc_luma_fir_stream.md
Name: hevc_luma_fir_stream

Overview:
- Streaming, parametrised HEVC luma 8-tap sub-pixel interpolation filter.
- Processes LANES output samples per beat from one row window, using valid/ready handshakes at both ports.
- Successor to the fixed 15x15 block interpolator: arbitrary bit depth and lane count, per-block fractional phase, final or intermediate output mode, and backpressure.
- Sits between the reference-pixel fetch buffer and the prediction/vertical-pass stage.

Parameters:
- LANES, 8: output samples per beat.
- BIT_DEPTH, 8: input pixel width, legal range 8..12.
- BLOCK_H, 8: rows (beats) per block; row counter wraps here.
- ROW_W, $clog2(BLOCK_H): width of out_row.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_pixels  in  (LANES+7)*BIT_DEPTH  window; pixel k is at [k*BIT_DEPTH +: BIT_DEPTH].
- in_frac  in  2  phase: 0 integer, 1 quarter, 2 half, 3 three-quarter.
- in_mode  in  1  0 = final clipped sample, 1 = 16-bit intermediate.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*16  lane i is at [i*16 +: 16].
- out_row  out  ROW_W  row index within block.
- out_last  out  1  out_row == BLOCK_H-1.

Behaviour:
- Reset (rst=0): all outputs 0 and pipeline emptied. in_ready goes to 1 on the first clock after deassertion. Row counter and held config are cleared. Reset mid-block discards in-flight beats.
- Handshake: a transfer occurs when valid && ready. out_data, out_row and out_last stay stable while out_valid && !out_ready.
- Pipeline: 2 stages.
  - S1: per-tap signed products.
  - S2: adder tree, rounding, shift and clip.
  - Latency is 2 cycles from accept to out_valid when not stalled.
  - Each stage advances when it is empty or the next stage advances.
  - in_ready = !S1_valid || S1 advances.
  - Full throughput is 1 beat/cycle. No bubbles are inserted under continuous out_ready.
- Lane i filters pixels i..i+7 (tap 0 = pixel i) and produces the sample between pixels i+3 and i+4.
- Coefficients:
  - frac1: -1,4,-10,58,17,-5,1,0
  - frac2: -1,4,-11,40,40,-11,4,-1
  - frac3: 0,1,-5,17,58,-10,4,-1
  - frac0: pixel i+3 is passed through.
- Arithmetic: accumulator is signed, width BIT_DEPTH+8.
  - Final mode, frac≠0: (sum+32)>>>6, clipped to [0, 2^BIT_DEPTH-1], zero-extended to 16 bits.
  - Intermediate mode, frac≠0: sum>>>(BIT_DEPTH-8), signed 16-bit.
  - Final mode, frac0: the pixel.
  - Intermediate mode, frac0: pixel<<(14-BIT_DEPTH).
- Block state machine, states IDLE and IN_BLOCK:
  - A beat accepted in IDLE latches in_frac and in_mode, sets row=0 and moves to IN_BLOCK.
  - While in IN_BLOCK, in_frac and in_mode are ignored.
  - Each accepted beat increments row.
  - The beat with row == BLOCK_H-1 returns the FSM to IDLE, so the next block may change phase.
  - Row and config travel with the beat through the pipeline.
- Simultaneous out handshake and in handshake in the same cycle with a full pipeline: both proceed, with no loss or duplication.

Optional Feature:
- Macro HEVC_FIR_CLIP_STATS_EN.
- When defined, adds port clip_cnt (out, 16 bits): a saturating count of final-mode lane samples clipped at either bound, counted on output handshake. It is cleared by reset and held at 0xFFFF on saturation.
- When undefined, the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package hevc_interp_pkg holds:
  - the coefficient table (4x8 signed 7-bit);
  - frac encodings;
  - mode constants;
  - the intermediate width constant 16 and shift constant 6.
- One sub-module, hevc_fir8_lane: a single-lane 8-tap MAC with round/clip, instantiated LANES times via generate. It takes the pipeline enable as an input.

Test Plan:
- All pixels 128, frac2, final mode -> every lane 0x0080; out_row 0..7; out_last only on row 7.
- Window 0,0,0,0,255,255,255,255, frac1 -> lane0 final 52 (0x0034); intermediate mode -> 0x0CF3.
- Window 255,255,255,0,0,255,255,255, frac2 -> final 0x0000 (clip low); intermediate 0xF010. Window 0,0,0,255,255,0,0,0, frac2 -> final 255 (clip high). With HEVC_FIR_CLIP_STATS_EN, clip_cnt increments by 1 per clipped lane.
- frac0, pixel 3 = 200 -> final 200; intermediate 12800 (0x3200). Changing in_frac to 2 on row 3 has no effect until the next block.
- Random out_ready toggling over 64 continuous beats -> output sequence exactly matches the reference model, data is stable during stalls, and 1 beat/cycle is achieved when out_ready=1.
- Assert rst low with 2 beats in flight mid-block -> out_valid=0 immediately. The next accepted beat has out_row=0 and uses newly sampled frac/mode.
